// File: rtl/mat_pkg.sv
// ============================================================================
// Module      : mat_pkg
// Description : Shared definitions for the matrix command sequencer: matrix
//               opcodes, sequencer state encoding and array-buffer select
//               encoding, plus a helper that maps a load opcode to its buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mat_pkg;

    // Matrix opcodes presented by the decode stage
    localparam logic [6:0] OP_MATMUL = 7'h50;
    localparam logic [6:0] OP_LAM    = 7'h51;
    localparam logic [6:0] OP_LBM    = 7'h52;
    localparam logic [6:0] OP_LACC   = 7'h53;
    localparam logic [6:0] OP_RACC   = 7'h54;

    // Array buffer select encoding
    localparam logic [1:0] BUF_SEL_A   = 2'd0;
    localparam logic [1:0] BUF_SEL_B   = 2'd1;
    localparam logic [1:0] BUF_SEL_ACC = 2'd2;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MUL   = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    // Destination buffer for a load-type opcode
    function automatic logic [1:0] load_sel(input logic [6:0] op);
        logic [1:0] sel;
        sel = BUF_SEL_A;
        if (op == OP_LBM) begin
            sel = BUF_SEL_B;
        end else if (op == OP_LACC) begin
            sel = BUF_SEL_ACC;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mat_cmd_seq_if.sv
// ============================================================================
// Module      : mat_cmd_seq_if
// Description : Bundle of the sequencer's external channels.
//               Command : cmd_valid, cmd_op, cmd_base / cmd_ready, busy
//               Memory  : mem_req, mem_we, mem_addr, mem_wdata / mem_gnt,
//                         mem_rvalid, mem_rdata
//               Buffer  : buf_we, buf_sel, buf_idx, buf_wdata
//               Accum   : acc_re, acc_idx / acc_rdata
//               Array   : arr_start / arr_done
//               master = sequencer side, slave = surrounding system side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mat_cmd_seq_if #(
    parameter int DIM = 4
) ();
    localparam int IW = $clog2(DIM * DIM);

    logic          cmd_valid;
    logic [6:0]    cmd_op;
    logic [31:0]   cmd_base;
    logic          cmd_ready;
    logic          busy;

    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;

    logic          buf_we;
    logic [1:0]    buf_sel;
    logic [IW-1:0] buf_idx;
    logic [31:0]   buf_wdata;

    logic          acc_re;
    logic [IW-1:0] acc_idx;
    logic [31:0]   acc_rdata;

    logic          arr_start;
    logic          arr_done;

    modport master (
        input  cmd_valid, cmd_op, cmd_base,
        output cmd_ready, busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output buf_we, buf_sel, buf_idx, buf_wdata,
        output acc_re, acc_idx,
        input  acc_rdata,
        output arr_start,
        input  arr_done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base,
        input  cmd_ready, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  buf_we, buf_sel, buf_idx, buf_wdata,
        input  acc_re, acc_idx,
        output acc_rdata,
        input  arr_start,
        output arr_done
    );

endinterface

`default_nettype wire

// File: rtl/mat_addr_ctr.sv
// ============================================================================
// Module      : mat_addr_ctr
// Description : Element index counter with a word address generator
//               (o_addr = i_base + 4*o_idx, modulo 2^32).
//               i_clr restarts the count, i_inc advances it by one.
// Ports       : clk, rst, i_clr, i_inc, i_base[31:0] -> o_idx[CW-1:0],
//               o_addr[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_addr_ctr #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [31:0]   i_base,
    output logic [CW-1:0] o_idx,
    output logic [31:0]   o_addr
);

    logic [CW-1:0] r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + CW'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_addr = i_base + {{(30 - CW){1'b0}}, r_idx, 2'b00};

endmodule

`default_nettype wire

// File: rtl/mat_cmd_seq.sv
// ============================================================================
// Module      : mat_cmd_seq
// Description : Matrix command sequencer. Accepts one matrix command at a
//               time and drives memory loads into the array buffers (lam,
//               lbm, lacc), the systolic array run (matmul) or the
//               accumulator write-back to memory (racc).
// Ports       : clk, rst   - clock and synchronous active-high reset
//               bus        - mat_cmd_seq_if.master (command, memory, buffer,
//                            accumulator and array channels)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_cmd_seq
    import mat_pkg::*;
#(
    parameter int DIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    mat_cmd_seq_if.master bus
);

    localparam int c_N  = DIM * DIM;
    localparam int c_IW = $clog2(c_N);
    localparam int c_CW = c_IW + 1;   // one extra bit so a counter can hold N
    localparam logic [c_CW-1:0] c_N_CNT = c_CW'(c_N);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_N - 1);

    state_t      r_state;
    logic [31:0] r_base;
    logic [1:0]  r_sel;
    logic        r_arr_start;
    logic        r_acc_re;     // accumulator read issued this cycle
    logic        r_rd_pend;    // accumulator data arrives this cycle
    logic        r_wr_pend;    // write request outstanding
    logic [31:0] r_wdata;

    logic            w_accept;
    logic            w_load_issue;
    logic            w_buf_we;
    logic            w_wr_done;
    logic [c_CW-1:0] w_issue_idx;
    logic [31:0]     w_issue_addr;
    logic [c_CW-1:0] w_ret_idx;
    logic [31:0]     w_ret_addr_unused;   // returns only need the index
    logic [c_CW-1:0] w_st_idx;
    logic [31:0]     w_st_addr;

    assign w_accept     = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_load_issue = (r_state == ST_LOAD) && (w_issue_idx < c_N_CNT);
    assign w_buf_we     = (r_state == ST_LOAD) && bus.mem_rvalid;
    assign w_wr_done    = r_wr_pend && bus.mem_gnt;

    // Read requests issued during LOAD
    mat_addr_ctr #(.CW(c_CW)) u_issue_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_inc  (w_load_issue && bus.mem_gnt),
        .i_base (r_base),
        .o_idx  (w_issue_idx),
        .o_addr (w_issue_addr)
    );

    // Read data returned during LOAD
    mat_addr_ctr #(.CW(c_CW)) u_ret_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_inc  (w_buf_we),
        .i_base (r_base),
        .o_idx  (w_ret_idx),
        .o_addr (w_ret_addr_unused)
    );

    // Accumulator element being written back during STORE
    mat_addr_ctr #(.CW(c_CW)) u_store_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_inc  (w_wr_done),
        .i_base (r_base),
        .o_idx  (w_st_idx),
        .o_addr (w_st_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_sel       <= BUF_SEL_A;
            r_arr_start <= 1'b0;
            r_acc_re    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_wr_pend   <= 1'b0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_MATMUL: begin
                                r_state     <= ST_MUL;
                                r_arr_start <= 1'b1;
                            end
                            OP_LAM, OP_LBM, OP_LACC: begin
                                r_state <= ST_LOAD;
                                r_base  <= bus.cmd_base;
                                r_sel   <= load_sel(bus.cmd_op);
                            end
                            OP_RACC: begin
                                r_state  <= ST_STORE;
                                r_base   <= bus.cmd_base;
                                r_acc_re <= 1'b1;
                            end
                            default: begin
                                // unknown opcode: consumed without effect
                            end
                        endcase
                    end
                end

                ST_LOAD: begin
                    if (w_buf_we && (w_ret_idx == c_LAST)) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_MUL: begin
                    r_arr_start <= 1'b0;
                    // arr_done during the start cycle is honoured as well
                    if (bus.arr_done) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_STORE: begin
                    // read -> data -> write, one element at a time
                    r_acc_re  <= 1'b0;
                    r_rd_pend <= r_acc_re;
                    if (r_rd_pend) begin
                        r_wdata   <= bus.acc_rdata;
                        r_wr_pend <= 1'b1;
                    end
                    if (w_wr_done) begin
                        r_wr_pend <= 1'b0;
                        if (w_st_idx == c_LAST) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_acc_re <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);

    assign bus.mem_req   = w_load_issue || r_wr_pend;
    assign bus.mem_we    = r_wr_pend;
    assign bus.mem_addr  = (r_state == ST_STORE) ? w_st_addr : w_issue_addr;
    assign bus.mem_wdata = r_wdata;

    assign bus.buf_we    = w_buf_we;
    assign bus.buf_sel   = r_sel;
    assign bus.buf_idx   = w_ret_idx[c_IW-1:0];
    assign bus.buf_wdata = w_buf_we ? bus.mem_rdata : 32'd0;

    assign bus.acc_re    = r_acc_re;
    assign bus.acc_idx   = w_st_idx[c_IW-1:0];
    assign bus.arr_start = r_arr_start;

endmodule

`default_nettype wire

// File: tb/tb_mat_cmd_seq.sv
// ============================================================================
// Module      : tb_mat_cmd_seq
// Description : Directed self-checking bench for mat_cmd_seq (DIM=4).
//               A memory/accumulator/array responder model runs alongside a
//               linear sequence of directed command steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_cmd_seq;

    localparam int DIM = 4;
    localparam int N   = DIM * DIM;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mat_cmd_seq_if #(.DIM(DIM)) bus ();

    mat_cmd_seq #(.DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input bit ok,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- model
    int          cyc;
    bit          gnt_mode;
    int          rd_due[$];
    logic [31:0] rd_dat[$];
    int          arr_due;
    bit          acc_pend;
    logic [31:0] acc_pend_idx;

    logic [31:0] rq_addr[$];
    logic        rq_we[$];
    logic [31:0] rq_data[$];
    logic [3:0]  bw_idx[$];
    logic [31:0] bw_data[$];
    logic [1:0]  bw_sel[$];

    int busy_cnt, arr_start_cnt, act_cnt, fall_cyc, last_bw_cyc;
    bit prev_req, prev_gnt, prev_we, prev_rst, prev_busy;
    logic [31:0] prev_addr, prev_wdata;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a * 32'h0000_9E37 + 32'h0000_1234;
    endfunction

    initial begin
        cyc = 0; arr_due = -1; acc_pend = 1'b0; acc_pend_idx = '0;
        prev_req = 1'b0; prev_gnt = 1'b0; prev_we = 1'b0; prev_rst = 1'b1;
        prev_busy = 1'b0; prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.mem_gnt = (gnt_mode && (cyc % 3 == 0)) ? 1'b0 : 1'b1;
            if (rd_due.size() > 0 && rd_due[0] <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rd_dat[0];
                void'(rd_due.pop_front());
                void'(rd_dat.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end
            bus.arr_done = (arr_due == cyc);
            if (acc_pend) begin
                bus.acc_rdata = acc_pend_idx * 32'd3;
                acc_pend = 1'b0;
            end
            #1;
            if (prev_req && !prev_gnt && !prev_rst) begin
                check("req_hold", bus.mem_req === 1'b1, bus.mem_req, 1'b1);
                check("addr_hold", bus.mem_addr === prev_addr, bus.mem_addr, prev_addr);
                check("we_hold", bus.mem_we === prev_we, bus.mem_we, prev_we);
                if (prev_we)
                    check("wdata_hold", bus.mem_wdata === prev_wdata, bus.mem_wdata, prev_wdata);
            end
            if (bus.mem_req && bus.mem_gnt) begin
                rq_addr.push_back(bus.mem_addr);
                rq_we.push_back(bus.mem_we);
                rq_data.push_back(bus.mem_wdata);
                if (!bus.mem_we) begin
                    rd_due.push_back(cyc + 2);
                    rd_dat.push_back(mem_val(bus.mem_addr));
                end
            end
            if (bus.buf_we) begin
                bw_idx.push_back(bus.buf_idx);
                bw_data.push_back(bus.buf_wdata);
                bw_sel.push_back(bus.buf_sel);
                last_bw_cyc = cyc;
            end
            if (bus.acc_re) begin
                acc_pend     = 1'b1;
                acc_pend_idx = 32'(bus.acc_idx);
            end
            if (bus.arr_start) begin
                arr_start_cnt++;
                arr_due = cyc + 10;
            end
            if (bus.busy) busy_cnt++;
            if (bus.mem_req || bus.buf_we || bus.arr_start || bus.acc_re) act_cnt++;
            if (prev_busy && !bus.busy) fall_cyc = cyc;
            prev_req   = bus.mem_req;
            prev_gnt   = bus.mem_gnt;
            prev_we    = bus.mem_we;
            prev_addr  = bus.mem_addr;
            prev_wdata = bus.mem_wdata;
            prev_rst   = rst;
            prev_busy  = bus.busy;
        end
    end

    // ---------------------------------------------------------------- tasks
    bit timed_out;

    task automatic clear_logs();
        rq_addr.delete(); rq_we.delete(); rq_data.delete();
        bw_idx.delete(); bw_data.delete(); bw_sel.delete();
        busy_cnt = 0; arr_start_cnt = 0; act_cnt = 0;
    endtask

    task automatic send(input logic [6:0] op, input logic [31:0] base);
        @(negedge clk); #2;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        @(negedge clk); #2;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (bus.busy && n < max_cyc) begin
            @(negedge clk); #2;
            n++;
        end
        timed_out = bus.busy;
        check(tag, timed_out === 1'b0, timed_out, 1'b0);
    endtask

    task automatic check_load(input logic [31:0] base, input logic [1:0] sel);
        check("load_req_count", rq_addr.size() == N, rq_addr.size(), N);
        check("load_buf_count", bw_idx.size() == N, bw_idx.size(), N);
        for (int i = 0; i < N && i < rq_addr.size(); i++) begin
            check("load_addr", rq_addr[i] === base + 32'(4 * i), rq_addr[i], base + 32'(4 * i));
            check("load_we", rq_we[i] === 1'b0, rq_we[i], 1'b0);
        end
        for (int i = 0; i < N && i < bw_idx.size(); i++) begin
            check("buf_idx", bw_idx[i] === 4'(i), bw_idx[i], 4'(i));
            check("buf_wdata", bw_data[i] === mem_val(base + 32'(4 * i)),
                  bw_data[i], mem_val(base + 32'(4 * i)));
            check("buf_sel", bw_sel[i] === sel, bw_sel[i], sel);
        end
    endtask

    // ---------------------------------------------------------------- steps
    initial begin
        errors = 0; checks = 0; gnt_mode = 1'b0;
        fall_cyc = 0; last_bw_cyc = 0;
        busy_cnt = 0; arr_start_cnt = 0; act_cnt = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_base = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.acc_rdata = '0; bus.arr_done = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_cmd_ready", bus.cmd_ready === 1'b1, bus.cmd_ready, 1'b1);
        check("rst_busy", bus.busy === 1'b0, bus.busy, 1'b0);
        check("rst_mem_req", bus.mem_req === 1'b0, bus.mem_req, 1'b0);
        check("rst_mem_we", bus.mem_we === 1'b0, bus.mem_we, 1'b0);
        check("rst_buf_we", bus.buf_we === 1'b0, bus.buf_we, 1'b0);
        check("rst_acc_re", bus.acc_re === 1'b0, bus.acc_re, 1'b0);
        check("rst_arr_start", bus.arr_start === 1'b0, bus.arr_start, 1'b0);
        check("rst_mem_addr", bus.mem_addr === 32'h0, bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata === 32'h0, bus.mem_wdata, 32'h0);
        check("rst_buf_idx", bus.buf_idx === 4'h0, bus.buf_idx, 4'h0);
        check("rst_buf_wdata", bus.buf_wdata === 32'h0, bus.buf_wdata, 32'h0);
        check("rst_acc_idx", bus.acc_idx === 4'h0, bus.acc_idx, 4'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        clear_logs();
        send(mat_pkg::OP_LAM, 32'h0000_0100);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = mat_pkg::OP_MATMUL;
        repeat (3) @(negedge clk);
        #2;
        bus.cmd_valid = 1'b0;
        wait_idle(200, "lam_timeout");
        check_load(32'h0000_0100, 2'd0);
        check("lam_busy_fall", fall_cyc == last_bw_cyc + 1, fall_cyc, last_bw_cyc + 1);
        check("busy_cmd_ignored", arr_start_cnt == 0, arr_start_cnt, 0);

        repeat (4) @(negedge clk);
        clear_logs();
        gnt_mode = 1'b1;
        send(mat_pkg::OP_LBM, 32'h0000_0180);
        wait_idle(300, "lbm_timeout");
        check_load(32'h0000_0180, 2'd1);
        gnt_mode = 1'b0;

        repeat (4) @(negedge clk);
        clear_logs();
        send(mat_pkg::OP_MATMUL, 32'h0);
        wait_idle(100, "mul_timeout");
        check("mul_busy_cycles", busy_cnt == 11, busy_cnt, 11);
        check("mul_start_pulses", arr_start_cnt == 1, arr_start_cnt, 1);
        check("mul_cmd_ready", bus.cmd_ready === 1'b1, bus.cmd_ready, 1'b1);

        repeat (4) @(negedge clk);
        clear_logs();
        gnt_mode = 1'b1;
        send(mat_pkg::OP_RACC, 32'h0000_0200);
        wait_idle(500, "racc_timeout");
        check("racc_write_count", rq_addr.size() == N, rq_addr.size(), N);
        for (int i = 0; i < N && i < rq_addr.size(); i++) begin
            check("racc_addr", rq_addr[i] === 32'h0000_0200 + 32'(4 * i),
                  rq_addr[i], 32'h0000_0200 + 32'(4 * i));
            check("racc_we", rq_we[i] === 1'b1, rq_we[i], 1'b1);
            check("racc_data", rq_data[i] === 32'(3 * i), rq_data[i], 32'(3 * i));
        end
        gnt_mode = 1'b0;

        repeat (4) @(negedge clk);
        clear_logs();
        send(7'h01, 32'h0000_0500);
        repeat (4) @(negedge clk);
        #2;
        check("nop_busy_cycles", busy_cnt == 0, busy_cnt, 0);
        check("nop_activity", act_cnt == 0, act_cnt, 0);
        check("nop_cmd_ready", bus.cmd_ready === 1'b1, bus.cmd_ready, 1'b1);

        clear_logs();
        send(mat_pkg::OP_LAM, 32'h0000_0300);
        begin
            int n;
            n = 0;
            while (bw_idx.size() < 5 && n < 100) begin
                @(negedge clk); #2;
                n++;
            end
            timed_out = (bw_idx.size() < 5);
            check("mid_rst_wait", timed_out === 1'b0, timed_out, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk); #2;
        check("mid_rst_busy", bus.busy === 1'b0, bus.busy, 1'b0);
        check("mid_rst_mem_req", bus.mem_req === 1'b0, bus.mem_req, 1'b0);
        check("mid_rst_buf_we", bus.buf_we === 1'b0, bus.buf_we, 1'b0);
        check("mid_rst_acc_re", bus.acc_re === 1'b0, bus.acc_re, 1'b0);
        check("mid_rst_arr_start", bus.arr_start === 1'b0, bus.arr_start, 1'b0);
        check("mid_rst_mem_addr", bus.mem_addr === 32'h0, bus.mem_addr, 32'h0);
        check("mid_rst_buf_idx", bus.buf_idx === 4'h0, bus.buf_idx, 4'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        clear_logs();
        send(mat_pkg::OP_LACC, 32'h0000_0400);
        wait_idle(200, "lacc_timeout");
        check_load(32'h0000_0400, 2'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/mat_cmd_seq.md
MAT_CMD_SEQ -- requirements
Module: mat_cmd_seq

Interface
REQ-001 Parameter DIM, default 4, matrix dimension; the element count is N=DIM*DIM and the index width is IW=$clog2(N).
REQ-002 clk  in  1  sole clock; all logic acts on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  the decode stage presents a matrix command.
REQ-005 cmd_op  in  7  opcode: 0x50 matmul, 0x51 lam, 0x52 lbm, 0x53 lacc, 0x54 racc.
REQ-006 cmd_base  in  32  byte base address (rs1 value) for lam/lbm/lacc/racc.
REQ-007 cmd_ready  out  1  the sequencer accepts a command this cycle.
REQ-008 busy  out  1  a command is in progress; the pipeline stalls the next matrix op.
REQ-009 mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0]  out  memory request channel.
REQ-010 mem_gnt  in  1  the request is accepted this cycle.
REQ-011 mem_rvalid, mem_rdata[31:0]  in  read return; returns arrive in order, 1 or more cycles after mem_gnt.
REQ-012 buf_we  out  1, buf_sel  out  2 (0=A, 1=B, 2=ACC), buf_idx  out  IW, buf_wdata  out  32  array buffer write port.
REQ-013 acc_re  out  1, acc_idx  out  IW, acc_rdata  in  32  accumulator read port; data is valid 1 cycle after acc_re.
REQ-014 arr_start  out  1, arr_done  in  1  systolic array start pulse and completion pulse.

Function
REQ-015 A command is accepted when cmd_valid and cmd_ready are both high; cmd_ready=1 only in IDLE, and busy=(state!=IDLE).
REQ-016 States: IDLE, LOAD, MUL, STORE.
REQ-017 An accepted opcode outside 0x50-0x54 is consumed as a NOP: the sequencer stays in IDLE and produces no output activity.
REQ-018 lam/lbm/lacc: IDLE->LOAD; buf_sel is latched to 0/1/2, the base is latched, and the issue count and return count are cleared.
REQ-019 LOAD: mem_req=1, mem_we=0 and mem_addr=base+4*issue while issue<N; issue increments only on mem_gnt.
REQ-020 LOAD: each mem_rvalid gives buf_we=1, buf_idx=ret and buf_wdata=mem_rdata in the same cycle, then ret increments.
REQ-021 LOAD exits to IDLE in the cycle after the N-th return, so latency is at least N+1 cycles.
REQ-022 A mem_rvalid that arrives while issue<N is legal, and issue and return proceed concurrently.
REQ-023 matmul: IDLE->MUL with arr_start=1 for exactly the first MUL cycle.
REQ-024 MUL stays until arr_done=1, then goes to IDLE in the next cycle; an arr_done in the arr_start cycle counts as done.
REQ-025 racc: IDLE->STORE.
REQ-026 STORE: acc_re reads index k, and one cycle later mem_req=1, mem_we=1, mem_addr=base+4*k and mem_wdata=acc_rdata (registered).
REQ-027 STORE holds mem_req and mem_wdata stable until mem_gnt, and issues no further acc_re while a write is pending.
REQ-028 STORE goes to IDLE in the cycle after the N-th granted write.
REQ-029 The index and address counters do not wrap in use: the last address is base+4*(N-1).
REQ-030 32-bit address arithmetic wraps modulo 2^32.
REQ-031 mem_req never drops before mem_gnt, and mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_gnt=0.
REQ-032 cmd_valid is ignored while busy=1, and no command is queued.

Reset
REQ-033 When rst=1 at a clock edge: state=IDLE, all counters=0, and mem_req, mem_we, buf_we, acc_re and arr_start=0.
REQ-034 After reset, cmd_ready=1 and busy=0.
REQ-035 Reset mid-operation abandons the command, and any mem_rvalid after reset is ignored.
REQ-036 Data outputs (mem_addr, mem_wdata, buf_wdata, buf_idx, acc_idx) are 0 after reset.

Structure
REQ-037 The shared package mat_pkg holds the opcode constants (OP_MATMUL..OP_RACC), the state enum and the buf_sel encoding.
REQ-038 A single sub-module, mat_addr_ctr (index counter plus base+4*idx address generator), is instantiated for the issue, return and store counters.

Verification
REQ-039 lam with base=0x100, DIM=4, mem_gnt=1 and read latency 2 -> 16 requests at 0x100..0x13C, buf_sel=0, buf_idx 0..15 written with the returned data, and busy falls after the 16th return.
REQ-040 lbm with mem_gnt low on every 3rd cycle -> addresses are held stable while waiting, there are no duplicate or skipped indices, and buf_sel=1.
REQ-041 matmul with arr_done asserted 10 cycles after arr_start -> arr_start is a 1-cycle pulse, busy is high for 11 cycles, and cmd_ready returns to 1.
REQ-042 racc with base=0x200 and acc_rdata=idx*3 -> 16 writes at 0x200..0x23C with data 0,3,...,45, and the writes hold under mem_gnt stalls.
REQ-043 rst asserted after the 5th return of a lam -> next cycle IDLE with all strobes 0, and a later lacc loads the full N elements cleanly.
REQ-044 cmd_op=0x01 with cmd_valid=1 -> accepted, busy stays 0, and there is no mem_req, buf_we or arr_start.
